// File: rtl/gio_pkg.sv
// gio_pkg: register offsets and address stride shared by
// the GPIO bank and its per-port slices.
package gio_pkg;

    localparam logic [1:0] OFS_DATA     = 2'd0;
    localparam logic [1:0] OFS_DIR      = 2'd1;
    localparam logic [1:0] OFS_IRQ_EN   = 2'd2;
    localparam logic [1:0] OFS_IRQ_FLAG = 2'd3;

    localparam int PORT_STRIDE = 4;

endpackage

// File: rtl/gio_port.sv
// gio_port: one GPIO port - data/dir/irq-enable registers,
// input synchronizer, rising-edge detector and sticky flags.
module gio_port
    import gio_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [1:0]       ofs_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [WIDTH-1:0] pin_i,
    output logic [WIDTH-1:0] pin_out_o,
    output logic [WIDTH-1:0] pin_oe_o,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] irq_en_o,
    output logic [WIDTH-1:0] irq_flag_o
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] en_q;
    logic [WIDTH-1:0] flag_q;
    logic [WIDTH-1:0] flag_d;
    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;

    // History follows the synced pin even while driving, so
    // flipping DIR back to input never fakes an edge.
    assign rise = s2_q & ~prev_q & ~dir_q;

    always_comb begin
        flag_d = flag_q;
        if (wr_i && ofs_i == OFS_IRQ_FLAG)
            flag_d = flag_q & ~wdata_i;
        flag_d = flag_d | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q  <= '0;
            dir_q  <= '0;
            en_q   <= '0;
            flag_q <= '0;
            s1_q   <= '0;
            s2_q   <= '0;
            prev_q <= '0;
        end else begin
            s1_q   <= pin_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            flag_q <= flag_d;
            if (wr_i) begin
                case (ofs_i)
                    OFS_DATA:   out_q <= wdata_i;
                    OFS_DIR:    dir_q <= wdata_i;
                    OFS_IRQ_EN: en_q  <= wdata_i;
                    default:    ;
                endcase
            end
        end
    end

    assign pin_out_o  = out_q;
    assign pin_oe_o   = dir_q;
    assign data_o     = (dir_q & out_q) | (~dir_q & s2_q);
    assign irq_en_o   = en_q;
    assign irq_flag_o = flag_q;

endmodule

// File: rtl/gio_bank.sv
// gio_bank: bank of GPIO ports behind a byte register map,
// with registered read data and a registered interrupt line.
module gio_bank
    import gio_pkg::*;
#(
    parameter int         N_PORTS   = 2,
    parameter int         WIDTH     = 8,
    parameter logic [7:0] BASE_ADDR = 8'h10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 address,
    input  logic [7:0]                 value_in,
    input  logic                       wen,
    input  logic                       ren,
    output logic [7:0]                 value_out,
    input  logic [N_PORTS*WIDTH-1:0]   pin_in,
    output logic [N_PORTS*WIDTH-1:0]   pin_out,
    output logic [N_PORTS*WIDTH-1:0]   pin_oe,
    output logic                       irq
);

    localparam logic [8:0] SPAN = 9'(PORT_STRIDE * N_PORTS);

    logic [7:0]       rel;
    logic             hit;
    logic [2:0]       sel;
    logic [1:0]       ofs;
    logic [7:0]       rdata;
    logic [7:0]       value_out_q;
    logic             irq_q;
    logic [N_PORTS-1:0] pend;

    logic [WIDTH-1:0] dat_w  [N_PORTS];
    logic [WIDTH-1:0] dir_w  [N_PORTS];
    logic [WIDTH-1:0] en_w   [N_PORTS];
    logic [WIDTH-1:0] flag_w [N_PORTS];

    assign rel = address - BASE_ADDR;
    assign hit = (address >= BASE_ADDR) && ({1'b0, rel} < SPAN);
    assign sel = rel[4:2];
    assign ofs = rel[1:0];

    for (genvar p = 0; p < N_PORTS; p++) begin : g_port
        gio_port #(.WIDTH(WIDTH)) u_port (
            .clk        (clk),
            .rst        (rst),
            .wr_i       (wen && hit && sel == 3'(p)),
            .ofs_i      (ofs),
            .wdata_i    (value_in[WIDTH-1:0]),
            .pin_i      (pin_in[p*WIDTH +: WIDTH]),
            .pin_out_o  (pin_out[p*WIDTH +: WIDTH]),
            .pin_oe_o   (dir_w[p]),
            .data_o     (dat_w[p]),
            .irq_en_o   (en_w[p]),
            .irq_flag_o (flag_w[p])
        );
        assign pin_oe[p*WIDTH +: WIDTH] = dir_w[p];
        assign pend[p] = |(flag_w[p] & en_w[p]);
    end

    always_comb begin
        rdata = 8'h00;
        for (int p = 0; p < N_PORTS; p++) begin
            if (hit && sel == 3'(p)) begin
                case (ofs)
                    OFS_DATA:   rdata[WIDTH-1:0] = dat_w[p];
                    OFS_DIR:    rdata[WIDTH-1:0] = dir_w[p];
                    OFS_IRQ_EN: rdata[WIDTH-1:0] = en_w[p];
                    default:    rdata[WIDTH-1:0] = flag_w[p];
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_out_q <= 8'h00;
            irq_q       <= 1'b0;
        end else begin
            if (ren)
                value_out_q <= rdata;
            irq_q <= |pend;
        end
    end

    assign value_out = value_out_q;
    assign irq       = irq_q;

endmodule

// File: tb/tb_gio_bank.sv
// tb_gio_bank: random plus directed stimulus against a
// behavioural register-map model, checked by a scoreboard.
module tb_gio_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  address = '0;
    logic [7:0]  value_in = '0;
    logic        wen = 1'b0;
    logic        ren = 1'b0;
    logic [7:0]  value_out;
    logic [15:0] pin_in = '0;
    logic [15:0] pin_out;
    logic [15:0] pin_oe;
    logic        irq;

    gio_bank #(.N_PORTS(2), .WIDTH(8), .BASE_ADDR(8'h10)) dut (
        .clk       (clk),
        .rst       (rst),
        .address   (address),
        .value_in  (value_in),
        .wen       (wen),
        .ren       (ren),
        .value_out (value_out),
        .pin_in    (pin_in),
        .pin_out   (pin_out),
        .pin_oe    (pin_oe),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] po;
        logic [15:0] oe;
        logic        irq;
        logic [7:0]  vo;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int failures = 0;

    // Behavioural state: registers per port and pin history,
    // where hist[k] is the pin value sampled k+1 edges ago.
    logic [7:0]  m_out[2], m_dir[2], m_en[2], m_flag[2];
    logic [15:0] hist[3];
    logic [7:0]  m_vo;
    logic        m_irq;

    function automatic void chk(string nm, logic [15:0] act,
                                logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int p = 0; p < 2; p++) begin
            m_out[p] = 0; m_dir[p] = 0;
            m_en[p] = 0;  m_flag[p] = 0;
        end
        for (int k = 0; k < 3; k++) hist[k] = 0;
        m_vo = 0;
        m_irq = 0;
    endfunction

    function automatic logic [7:0] synced(int p);
        return hist[1][p*8 +: 8];
    endfunction

    function automatic logic [7:0] mread(logic [7:0] a);
        int p, o;
        logic [7:0] r;
        if (a < 8'h10 || a > 8'h17) return 8'h00;
        p = (int'(a) - 16) / 4;
        o = (int'(a) - 16) % 4;
        r = 0;
        case (o)
            0: for (int b = 0; b < 8; b++)
                   r[b] = m_dir[p][b] ? m_out[p][b] : synced(p)[b];
            1: r = m_dir[p];
            2: r = m_en[p];
            default: r = m_flag[p];
        endcase
        return r;
    endfunction

    function automatic void model_edge();
        logic [7:0] rd;
        logic       irq_n;
        logic [7:0] rise[2];
        int p, o;
        rd = mread(address);
        irq_n = 0;
        for (int q = 0; q < 2; q++) begin
            if ((m_flag[q] & m_en[q]) != 0) irq_n = 1;
            rise[q] = synced(q) & ~hist[2][q*8 +: 8] & ~m_dir[q];
        end
        if (ren) m_vo = rd;
        if (wen && address >= 8'h10 && address <= 8'h17) begin
            p = (int'(address) - 16) / 4;
            o = (int'(address) - 16) % 4;
            case (o)
                0: m_out[p] = value_in;
                1: m_dir[p] = value_in;
                2: m_en[p]  = value_in;
                default: m_flag[p] = m_flag[p] & ~value_in;
            endcase
        end
        for (int q = 0; q < 2; q++) m_flag[q] |= rise[q];
        m_irq = irq_n;
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = pin_in;
    endfunction

    task automatic cycle(input logic w, input logic r,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic [15:0] pin);
        exp_t e;
        wen = w; ren = r; address = a; value_in = d; pin_in = pin;
        @(posedge clk);
        model_edge();
        e.po  = {m_out[1], m_out[0]};
        e.oe  = {m_dir[1], m_dir[0]};
        e.irq = m_irq;
        e.vo  = m_vo;
        sbq.push_back(e);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 8'h00, 8'h00, pin_in);
    endtask

    task automatic do_reset(input logic w, input logic [7:0] a,
                            input logic [7:0] d);
        wen = w; ren = 0; address = a; value_in = d;
        @(negedge clk);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        chk("rst_pin_oe", pin_oe, 16'h0000);
        chk("rst_pin_out", pin_out, 16'h0000);
        chk("rst_irq", {15'd0, irq}, 16'h0000);
        chk("rst_value_out", {8'd0, value_out}, 16'h0000);
        @(posedge clk);
        #1;
        wen = 0;
        @(negedge clk);
        #1;
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("pin_out", pin_out, e.po);
            chk("pin_oe", pin_oe, e.oe);
            chk("irq", {15'd0, irq}, {15'd0, e.irq});
            chk("value_out", {8'd0, value_out}, {8'd0, e.vo});
        end
    end

    logic [7:0] addrs[10] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14,
                              8'h15, 8'h16, 8'h17, 8'h20, 8'h0F};

    initial begin
        int wait_n;
        model_reset();
        pin_in = 16'hFFFF;
        do_reset(0, 8'h00, 8'h00);
        idle(3);
        cycle(1, 0, 8'h13, 8'hFF, 16'hFFFF);
        cycle(1, 0, 8'h17, 8'hFF, 16'hFFFF);
        // Drive port 0, readback through DATA
        cycle(1, 0, 8'h11, 8'hFF, 16'hFFFF);
        cycle(1, 0, 8'h10, 8'hA5, 16'hFFFF);
        cycle(0, 1, 8'h10, 8'h00, 16'hFFFF);
        idle(1);
        // Port 1 input path and unmapped read
        cycle(0, 0, 8'h00, 8'h00, 16'h3C00);
        idle(2);
        cycle(0, 1, 8'h14, 8'h00, 16'h3C00);
        cycle(0, 1, 8'h20, 8'h00, 16'h3C00);
        cycle(1, 0, 8'h17, 8'hFF, 16'h3C00);
        // Interrupt set and clear
        cycle(1, 0, 8'h16, 8'h01, 16'h3C00);
        cycle(0, 0, 8'h00, 8'h00, 16'h3D00);
        idle(3);
        cycle(0, 1, 8'h17, 8'h00, 16'h3D00);
        cycle(1, 0, 8'h17, 8'h01, 16'h3D00);
        idle(2);
        // Set and W1C on the same edge
        cycle(0, 0, 8'h00, 8'h00, 16'h3C00);
        idle(3);
        cycle(0, 0, 8'h00, 8'h00, 16'h3D00);
        idle(1);
        cycle(1, 0, 8'h17, 8'h01, 16'h3D00);
        idle(1);
        cycle(0, 1, 8'h17, 8'h00, 16'h3D00);
        idle(1);
        // Flag without enable, DIR toggle, mid-write reset
        cycle(1, 0, 8'h16, 8'h00, 16'h3D00);
        cycle(1, 0, 8'h17, 8'hFF, 16'h3C00);
        idle(3);
        cycle(0, 0, 8'h00, 8'h00, 16'h3D00);
        idle(3);
        cycle(0, 1, 8'h17, 8'h00, 16'h3D00);
        cycle(1, 0, 8'h15, 8'h01, 16'h3D00);
        cycle(1, 0, 8'h15, 8'h00, 16'h3D00);
        idle(3);
        cycle(0, 1, 8'h17, 8'h00, 16'h3D00);
        do_reset(1, 8'h10, 8'hFF);
        cycle(0, 1, 8'h10, 8'h00, 16'h3D00);
        cycle(0, 1, 8'h11, 8'h00, 16'h3D00);
        idle(1);
        for (int i = 0; i < 600; i++) begin
            logic [15:0] pn;
            pn = ($urandom_range(0, 3) == 0) ? 16'($urandom) : pin_in;
            cycle($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  addrs[$urandom_range(0, 9)], 8'($urandom), pn);
        end
        idle(3);
        wait_n = 0;
        while (sbq.size() > 0 && wait_n < 20) begin
            @(posedge clk);
            wait_n++;
        end
        if (sbq.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0",
                     sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
